// File: rtl/memacc_pkg.sv
// Shared types for the MEM-stage access controller: load opcodes, FSM states,
// the zero word and the alignment rule used when MEMACC_ALIGN_CHECK_EN is defined.
package memacc_pkg;

   typedef enum logic [2:0] {
      NOP = 3'd0,
      LB  = 3'd1,
      LBU = 3'd2,
      LH  = 3'd3,
      LHU = 3'd4,
      LW  = 3'd5
   } loadop_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   // Half-word accesses need an even address, word accesses a 4-byte aligned one.
   function automatic logic is_misaligned(input logic [2:0] lop,
                                          input logic [3:0] sel,
                                          input logic [1:0] lo);
      logic half_acc;
      logic word_acc;
      half_acc = (lop == LH) || (lop == LHU) || (sel == 4'b0011) || (sel == 4'b1100);
      word_acc = (lop == LW) || (sel == 4'b1111);
      return (half_acc && lo[0]) || (word_acc && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-bus bundle between the MEM stage (master) and the memory system (slave).
interface mem_access_stage_if #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32
);
   logic              busReq;
   logic              busWe;
   logic [ADDR_W-1:0] busAddr;
   logic [3:0]        busSel;
   logic [WORD_W-1:0] busWdata;
   logic [WORD_W-1:0] busRdata;
   logic              busAck;

   modport master (
      output busReq, busWe, busAddr, busSel, busWdata,
      input  busRdata, busAck
   );

   modport slave (
      input  busReq, busWe, busAddr, busSel, busWdata,
      output busRdata, busAck
   );
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half-word lane of a read word and sign- or
// zero-extends it according to the load opcode.
module load_align
   import memacc_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic [WORD_W-1:0] rdata,
   input  loadop_e           op,
   input  logic [1:0]        addr_lo,
   output logic [WORD_W-1:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[{addr_lo, 3'b000} +: 8];
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      data      = '0;
      case (op)
         LB:      data = {{(WORD_W-8){byte_lane[7]}}, byte_lane};
         LBU:     data = {{(WORD_W-8){1'b0}}, byte_lane};
         LH:      data = {{(WORD_W-16){half_lane[15]}}, half_lane};
         LHU:     data = {{(WORD_W-16){1'b0}}, half_lane};
         LW:      data = rdata;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: one req/ack bus transaction per memory op, pipeline stall
// while outstanding, MEM/WB register. Optional alignment trap: MEMACC_ALIGN_CHECK_EN.
module mem_access_stage
   import memacc_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              memEnable,
   input  logic [ADDR_W-1:0] ramAddr,
   input  logic [3:0]        ramSel,
   input  logic [2:0]        loadop,
   input  logic [WORD_W-1:0] storeData,
   input  logic [WORD_W-1:0] aluResult,
   input  logic              wbEnIn,
   input  logic [4:0]        wbAddrIn,
   mem_access_stage_if.master bus,
   output logic              stallReq,
   output logic              wbEn,
   output logic [4:0]        wbAddr,
   output logic [WORD_W-1:0] wbData,
   output logic              addrExc
);

   state_e            state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [3:0]        bus_sel_q, bus_sel_d;
   logic [WORD_W-1:0] bus_wdata_q, bus_wdata_d;
   loadop_e           ld_op_q, ld_op_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic              is_store_q, is_store_d;
   logic              wb_en_pend_q, wb_en_pend_d;
   logic [4:0]        wb_addr_pend_q, wb_addr_pend_d;
   logic              wb_en_q, wb_en_d;
   logic [4:0]        wb_addr_q, wb_addr_d;
   logic [WORD_W-1:0] wb_data_q, wb_data_d;
   logic              addr_exc_d;

   logic              mem_op;
   logic              is_store;
   logic              misaligned;
   logic [WORD_W-1:0] load_data;

   assign is_store = (ramSel != 4'b0000);
   assign mem_op   = memEnable && ((loadop != 3'(NOP)) || is_store);

`ifdef MEMACC_ALIGN_CHECK_EN
   logic addr_exc_q;
   assign misaligned = is_misaligned(loadop, ramSel, ramAddr[1:0]);
   assign addrExc    = addr_exc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) addr_exc_q <= 1'b0;
      else        addr_exc_q <= addr_exc_d;
   end
`else
   assign misaligned = 1'b0;
   assign addrExc    = 1'b0;
`endif

   load_align #(.WORD_W(WORD_W)) u_load_align (
      .rdata   (bus.busRdata),
      .op      (ld_op_q),
      .addr_lo (addr_lo_q),
      .data    (load_data)
   );

   // A trapped misaligned access never reaches BUSY, so it must not stall either.
   assign stallReq = ((state_q == IDLE) && mem_op && !misaligned) || (state_q == BUSY);

   always_comb begin
      state_d        = state_q;
      bus_req_d      = bus_req_q;
      bus_we_d       = bus_we_q;
      bus_addr_d     = bus_addr_q;
      bus_sel_d      = bus_sel_q;
      bus_wdata_d    = bus_wdata_q;
      ld_op_d        = ld_op_q;
      addr_lo_d      = addr_lo_q;
      is_store_d     = is_store_q;
      wb_en_pend_d   = wb_en_pend_q;
      wb_addr_pend_d = wb_addr_pend_q;
      wb_en_d        = 1'b0;
      wb_addr_d      = wb_addr_q;
      wb_data_d      = wb_data_q;
      addr_exc_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_op && misaligned) begin
               addr_exc_d = 1'b1;
            end else if (mem_op) begin
               bus_req_d      = 1'b1;
               bus_we_d       = is_store;
               bus_addr_d     = {ramAddr[ADDR_W-1:2], 2'b00};
               bus_sel_d      = is_store ? ramSel : 4'b1111;
               bus_wdata_d    = is_store ? storeData : WORD_W'(ZERO_WORD);
               ld_op_d        = loadop_e'(loadop);
               addr_lo_d      = ramAddr[1:0];
               is_store_d     = is_store;
               wb_en_pend_d   = wbEnIn && !is_store;
               wb_addr_pend_d = wbAddrIn;
               state_d        = BUSY;
            end else if (memEnable) begin
               wb_en_d   = wbEnIn;
               wb_addr_d = wbAddrIn;
               wb_data_d = aluResult;
            end
         end
         BUSY: begin
            if (bus.busAck) begin
               bus_req_d   = 1'b0;
               bus_we_d    = 1'b0;
               bus_addr_d  = '0;
               bus_sel_d   = 4'b0000;
               bus_wdata_d = WORD_W'(ZERO_WORD);
               wb_en_d     = wb_en_pend_q;
               wb_addr_d   = wb_addr_pend_q;
               wb_data_d   = is_store_q ? WORD_W'(ZERO_WORD) : load_data;
               state_d     = DONE;
            end
         end
         // The EX/MEM slot still holds the serviced instruction here; skip it.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         bus_req_q      <= 1'b0;
         bus_we_q       <= 1'b0;
         bus_addr_q     <= '0;
         bus_sel_q      <= 4'b0000;
         bus_wdata_q    <= '0;
         ld_op_q        <= NOP;
         addr_lo_q      <= 2'b00;
         is_store_q     <= 1'b0;
         wb_en_pend_q   <= 1'b0;
         wb_addr_pend_q <= 5'd0;
         wb_en_q        <= 1'b0;
         wb_addr_q      <= 5'd0;
         wb_data_q      <= '0;
      end else begin
         state_q        <= state_d;
         bus_req_q      <= bus_req_d;
         bus_we_q       <= bus_we_d;
         bus_addr_q     <= bus_addr_d;
         bus_sel_q      <= bus_sel_d;
         bus_wdata_q    <= bus_wdata_d;
         ld_op_q        <= ld_op_d;
         addr_lo_q      <= addr_lo_d;
         is_store_q     <= is_store_d;
         wb_en_pend_q   <= wb_en_pend_d;
         wb_addr_pend_q <= wb_addr_pend_d;
         wb_en_q        <= wb_en_d;
         wb_addr_q      <= wb_addr_d;
         wb_data_q      <= wb_data_d;
      end
   end

   assign bus.busReq   = bus_req_q;
   assign bus.busWe    = bus_we_q;
   assign bus.busAddr  = bus_addr_q;
   assign bus.busSel   = bus_sel_q;
   assign bus.busWdata = bus_wdata_q;
   assign wbEn         = wb_en_q;
   assign wbAddr       = wb_addr_q;
   assign wbData       = wb_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised bench for mem_access_stage: directed scenarios plus random memory and
// ALU traffic, each result predicted from the load/store rules with plain arithmetic.
module tb_mem_access_stage;
   import memacc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memEnable;
   logic [31:0] ramAddr;
   logic [3:0]  ramSel;
   logic [2:0]  loadop;
   logic [31:0] storeData;
   logic [31:0] aluResult;
   logic        wbEnIn;
   logic [4:0]  wbAddrIn;
   logic        stallReq;
   logic        wbEn;
   logic [4:0]  wbAddr;
   logic [31:0] wbData;
   logic        addrExc;

   int tests_run    = 0;
   int tests_failed = 0;

   mem_access_stage_if #(.ADDR_W(32), .WORD_W(32)) bus_if ();

   mem_access_stage #(.ADDR_W(32), .WORD_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .memEnable (memEnable),
      .ramAddr   (ramAddr),
      .ramSel    (ramSel),
      .loadop    (loadop),
      .storeData (storeData),
      .aluResult (aluResult),
      .wbEnIn    (wbEnIn),
      .wbAddrIn  (wbAddrIn),
      .bus       (bus_if.master),
      .stallReq  (stallReq),
      .wbEn      (wbEn),
      .wbAddr    (wbAddr),
      .wbData    (wbData),
      .addrExc   (addrExc)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference load result: pick the lane arithmetically, then extend by value range.
   function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] rd);
      logic [31:0] b;
      logic [31:0] h;
      b = (rd >> (8 * addr[1:0])) & 32'hFF;
      h = (rd >> (addr[1] ? 16 : 0)) & 32'hFFFF;
      case (op)
         LB:      return (b >= 32'd128) ? b - 32'd256 : b;
         LBU:     return b;
         LH:      return (h >= 32'd32768) ? h - 32'd65536 : h;
         LHU:     return h;
         LW:      return rd;
         default: return 32'd0;
      endcase
   endfunction

   task automatic do_op(input string nm, input bit me, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [2:0] lop, input logic [31:0] sd,
                        input logic [31:0] alu, input bit wbe, input logic [4:0] wba,
                        input logic [31:0] rd, input int dly);
      bit mem_op;
      bit store;
      bit mis;
      int stalls;
      memEnable = me;   ramAddr = addr;  ramSel = sel;  loadop = lop;
      storeData = sd;   aluResult = alu; wbEnIn = wbe;  wbAddrIn = wba;
      bus_if.busAck = 1'b0;
      bus_if.busRdata = $urandom;
      mem_op = me && (lop != 3'd0 || sel != 4'd0);
      store  = (sel != 4'd0);
      mis    = 1'b0;
`ifdef MEMACC_ALIGN_CHECK_EN
      if (mem_op) begin
         mis = (((lop == LH || lop == LHU || sel == 4'b0011 || sel == 4'b1100) && addr[0]) ||
                ((lop == LW || sel == 4'b1111) && addr[1:0] != 2'b00));
      end
`endif
      #1;
      if (!mem_op || mis) begin
         chk_eq({nm, ".stall_c0"}, stallReq, 1'b0);
         @(posedge clk); @(negedge clk); #1;
         chk_eq({nm, ".busReq"}, bus_if.busReq, 1'b0);
         chk_eq({nm, ".wbEn"}, wbEn, (me && wbe && !mis));
         if (me && !mis) begin
            chk_eq({nm, ".wbData"}, wbData, alu);
            chk_eq({nm, ".wbAddr"}, wbAddr, wba);
         end
         if (mis) begin
            chk_eq({nm, ".addrExc"}, addrExc, 1'b1);
            memEnable = 1'b0;
            @(posedge clk); @(negedge clk); #1;
            chk_eq({nm, ".addrExc_drop"}, addrExc, 1'b0);
         end
         $display("[TB] %s nonbus me=%0d wbEn=%0d wbData=%08h addrExc_seen=%0d", nm, me, wbEn, wbData, mis);
         return;
      end
      stalls = int'(stallReq);
      @(posedge clk); @(negedge clk); #1;
      chk_eq({nm, ".busReq"}, bus_if.busReq, 1'b1);
      chk_eq({nm, ".busWe"}, bus_if.busWe, store);
      chk_eq({nm, ".busAddr"}, bus_if.busAddr, addr & 32'hFFFF_FFFC);
      chk_eq({nm, ".busSel"}, bus_if.busSel, store ? sel : 4'b1111);
      chk_eq({nm, ".busWdata"}, bus_if.busWdata, store ? sd : 32'd0);
      chk_eq({nm, ".wbEn_stall"}, wbEn, 1'b0);
      for (int i = 0; i < dly; i++) begin
         stalls += int'(stallReq);
         @(posedge clk); @(negedge clk); #1;
         chk_eq({nm, ".busReq_hold"}, bus_if.busReq, 1'b1);
         chk_eq({nm, ".busAddr_hold"}, bus_if.busAddr, addr & 32'hFFFF_FFFC);
      end
      stalls += int'(stallReq);
      bus_if.busAck = 1'b1;
      bus_if.busRdata = rd;
      @(posedge clk); @(negedge clk);
      bus_if.busAck = 1'b0;
      #1;
      chk_eq({nm, ".stall_cycles"}, 64'(stalls), 64'(dly + 2));
      chk_eq({nm, ".stall_done"}, stallReq, 1'b0);
      chk_eq({nm, ".busReq_done"}, bus_if.busReq, 1'b0);
      chk_eq({nm, ".wbEn"}, wbEn, (wbe && !store));
      if (!store) begin
         chk_eq({nm, ".wbData"}, wbData, model_load(lop, addr, rd));
         chk_eq({nm, ".wbAddr"}, wbAddr, wba);
      end
      $display("[TB] %s addr=%08h sel=%h op=%0d dly=%0d stalls=%0d wbEn=%0d wbData=%08h",
               nm, addr, sel, lop, dly, stalls, wbEn, wbData);
      @(posedge clk); @(negedge clk); #1;
      chk_eq({nm, ".no_reissue"}, bus_if.busReq, 1'b0);
      chk_eq({nm, ".bubble"}, wbEn, 1'b0);
   endtask

   logic [3:0] sel_tbl [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0011, 4'b1100, 4'b1111, 4'b0001};

   initial begin
      rst_n = 1'b0; memEnable = 1'b0; ramAddr = '0; ramSel = '0; loadop = '0;
      storeData = '0; aluResult = '0; wbEnIn = 1'b0; wbAddrIn = '0;
      bus_if.busAck = 1'b0; bus_if.busRdata = '0;
      #12;
      chk_eq("rst.busReq", bus_if.busReq, 1'b0);
      chk_eq("rst.busSel", bus_if.busSel, 4'b0000);
      chk_eq("rst.wbEn", wbEn, 1'b0);
      chk_eq("rst.wbData", wbData, 32'd0);
      chk_eq("rst.addrExc", addrExc, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("add",  1'b1, 32'h0,   4'b0000, NOP, 32'h0, 32'h1234, 1'b1, 5'd5, 32'h0, 0);
      do_op("lb",   1'b1, 32'h103, 4'b0000, LB,  32'h0, 32'h0, 1'b1, 5'd7, 32'h80FF_0000, 2);
      do_op("lbu",  1'b1, 32'h103, 4'b0000, LBU, 32'h0, 32'h0, 1'b1, 5'd8, 32'h80FF_0000, 0);
      do_op("lh",   1'b1, 32'h102, 4'b0000, LH,  32'h0, 32'h0, 1'b1, 5'd9, 32'h8001_7FFF, 1);
      do_op("lhu",  1'b1, 32'h102, 4'b0000, LHU, 32'h0, 32'h0, 1'b1, 5'd10, 32'h8001_7FFF, 0);
      do_op("sb",   1'b1, 32'h201, 4'b0010, NOP, 32'hABAB_ABAB, 32'h0, 1'b1, 5'd3, 32'h0, 1);
      do_op("lw",   1'b1, 32'h3FC, 4'b0000, LW,  32'h0, 32'h0, 1'b1, 5'd11, 32'hDEAD_BEEF, 0);
      do_op("idle", 1'b0, 32'h104, 4'b0000, LW,  32'h0, 32'h55, 1'b1, 5'd12, 32'h0, 0);
`ifdef MEMACC_ALIGN_CHECK_EN
      do_op("lw_mis", 1'b1, 32'h102, 4'b0000, LW, 32'h0, 32'h0, 1'b1, 5'd4, 32'h0, 0);
`endif

      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         int kind;
         a = $urandom;
         kind = int'($urandom_range(0, 3));
         if (kind == 0)
            do_op("rnd_alu", 1'($urandom_range(0, 1)), a, 4'b0000, NOP, 32'h0, $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom), 32'h0, 0);
         else if (kind == 3)
            do_op("rnd_st", 1'b1, a, sel_tbl[$urandom_range(0, 7)], NOP, $urandom, 32'h0,
                  1'b1, 5'($urandom), 32'h0, int'($urandom_range(0, 3)));
         else
            do_op("rnd_ld", 1'b1, a, 4'b0000, 3'($urandom_range(1, 5)), 32'h0, 32'h0,
                  1'($urandom_range(0, 1)), 5'($urandom), $urandom, int'($urandom_range(0, 3)));
      end

      // Reset during the second BUSY cycle, with an ack arriving while reset is held.
      memEnable = 1'b1; ramAddr = 32'h300; ramSel = 4'b0000; loadop = LW; wbEnIn = 1'b1;
      wbAddrIn = 5'd6; bus_if.busAck = 1'b0; bus_if.busRdata = 32'h1111_2222;
      @(posedge clk); @(posedge clk);
      #2;
      rst_n = 1'b0;
      bus_if.busAck = 1'b1;
      #1;
      chk_eq("rstbusy.busReq", bus_if.busReq, 1'b0);
      chk_eq("rstbusy.busAddr", bus_if.busAddr, 32'd0);
      chk_eq("rstbusy.busWe", bus_if.busWe, 1'b0);
      chk_eq("rstbusy.wbEn", wbEn, 1'b0);
      chk_eq("rstbusy.wbData", wbData, 32'd0);
      chk_eq("rstbusy.wbAddr", wbAddr, 5'd0);
      memEnable = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      bus_if.busAck = 1'b0;
      #1;
      chk_eq("rstbusy.stall", stallReq, 1'b0);
      @(posedge clk); @(negedge clk); #1;
      chk_eq("rstbusy.no_wb", wbEn, 1'b0);
      chk_eq("rstbusy.no_req", bus_if.busReq, 1'b0);
      $display("[TB] rstbusy busReq=%0d wbEn=%0d wbData=%08h", bus_if.busReq, wbEn, wbData);

      do_op("post_rst", 1'b1, 32'h0, 4'b0000, NOP, 32'h0, 32'hCAFE, 1'b1, 5'd2, 32'h0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
